adc082s021_emu: RTL and testbench
=================================

# adc082s021_emu

Synthesizable responder for the ADC082S021 SPI conversion frame: the device end of the link our ADC master drives. It oversamples `ss`/`sclk`/`mosi` on a fast system clock and decodes the control byte. It returns 8-bit sample values supplied on parallel ports, using the converter's frame format and one-frame channel pipelining. It stands in for the real ADC in loopback and board-level tests, and fronts simulated or FPGA-generated analog sources.

## Interface
- `SYNC`, 2: synchronizer depth for `ss`, `sclk`, `mosi` (≥2).
- `clk` in 1: system clock. Must be ≥8× `sclk` frequency.
- `n_reset` in 1: asynchronous, active-low reset.
- `ss` in 1: chip select, active low.
- `sclk` in 1: serial clock. CPOL=1: idles high; `mosi` is sampled on rising edges and `miso` changes on falling edges.
- `mosi` in 1: control bits, MSB first.
- `miso` out 1: sample bits, MSB first. Driven 0 when not selected.
- `ch0_data` in 8: sample returned for channel 0.
- `ch1_data` in 8: sample returned for channel 1.
- `rx_ctrl` out 8: control byte from the last complete frame.
- `sample_ch` out 1: channel whose data is in the current or most recent frame.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-clk pulse when a frame completes.
- `frame_err` out 1: one-clk pulse when a frame is aborted.

## Operation
- Input synchronization:
  - `ss`, `sclk`, `mosi` each pass through `SYNC` flops.
  - Synchronizer reset values: `ss`=1, `sclk`=1, `mosi`=0.
  - A single registered previous-value stage feeds edge detection.
- Frame: 16 `sclk` rising edges while `ss` is low.
  - Rising edges 1–8 shift `mosi` into an 8-bit control register; rising edges 9–16 ignore `mosi`.
  - Channel for the next frame = control bit 3, i.e. ADD0 (bit order DC,DC,ADD2,ADD1,ADD0,x,x,x). ADD2/ADD1 are ignored.
- TX word: 16 bits, {4'b0, sample[7:0], 4'b0}.
  - Loaded on the `ss` falling-edge detect, from `ch0_data`/`ch1_data` selected by `next_ch`.
  - `miso` = TX[15] from the load onward.
  - Each falling `sclk` edge that follows at least one rising edge in the frame shifts TX left, filling with 0.
- State machine:
  - WAIT: entered from reset. Moves to IDLE once synchronized `ss`=1. Prevents a false frame if `ss` is low when reset is released.
  - IDLE: on `ss` falling edge, load TX, clear bit count, set `busy`, move to SHIFT.
  - SHIFT: count rising edges.
    - On the 16th rising edge: commit `rx_ctrl` and `next_ch`, pulse `frame_done`, move to DONE.
    - On `ss` rising edge before 16 edges: pulse `frame_err`, move to IDLE. `rx_ctrl` and `next_ch` are unchanged.
  - DONE: hold `miso`=0 after the final shift and ignore extra `sclk` edges. On `ss` rising edge, clear `busy` and move to IDLE.
- `sample_ch` updates at TX load and holds until the next load.
- Changes on `ch0_data`/`ch1_data` after TX load do not affect the current frame.
- Simultaneous `sclk` and `ss` edges in the same clk: the `ss` edge wins and the `sclk` edge is discarded.

## Timing
- Reset values (asynchronous):
  - State WAIT.
  - `miso`=0, `rx_ctrl`=0, `sample_ch`=0, `next_ch`=0, `busy`=0, `frame_done`=0, `frame_err`=0.
- Edge detect latency: SYNC+1 clk after a pin transition (3 clk with SYNC=2).
- `miso` update: SYNC+2 clk after the `sclk` falling pin edge. The master samples on the next rising edge, so the sclk half-period must be ≥4 clk.
- `frame_done`, `rx_ctrl`, `next_ch`: all update in the clk after the 16th rising-edge detect.
- `busy`: rises in the clk after `ss` fall detect; falls in the clk after `ss` rise detect.
- `n_reset` asserted mid-frame:
  - All outputs go to reset values immediately.
  - After release, no frame is recognized until `ss` has been observed high, then low.
- First frame after reset returns channel 0.

## Test plan
- Channel pipelining:
  - Setup: `ch0_data`=0xA5, `ch1_data`=0x3C, sclk=clk/32.
  - Frame 1 with mosi=0x08,0x00 → `miso` word 0x0A50, `rx_ctrl`=0x08, one `frame_done`.
  - Frame 2 with mosi=0x00 → `miso` word 0x03C0, `sample_ch`=1.
- Abort: raise `ss` after 7 rising edges → one `frame_err` and no `frame_done`. `rx_ctrl` is unchanged, and the next frame returns the previously selected channel.
- Overrun: 20 rising edges in one frame → exactly one `frame_done`. `miso`=0 after the 16th bit; `busy` clears only on `ss` high.
- Reset mid-frame: assert `n_reset` at bit 9 while `ss` stays low and `sclk` keeps toggling.
  - During reset: outputs are at reset values.
  - After release, while `ss` stays low: no `frame_done`.
  - After `ss` goes high then low: a normal frame returns channel-0 data.
- Data stability: change `ch0_data` 0x11→0xEE at bit 6 → the current frame returns 0x0110 and the next frame returns 0x0EE0.
- Minimum ratio: sclk=clk/8, 100 back-to-back frames with random control bytes and data → all words bit-exact, with no `frame_err`.

Source files
------------

// File: rtl/adc082s021_emu_if.sv
// adc082s021_emu_if: SPI link between an ADC master and the ADC082S021 responder
//   ss   - chip select, active low (master -> device)
//   sclk - serial clock, CPOL=1 (master -> device)
//   mosi - control bits, MSB first (master -> device)
//   miso - sample bits, MSB first (device -> master)
interface adc082s021_emu_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    modport master (output ss, sclk, mosi, input miso);
    modport slave  (input ss, sclk, mosi, output miso);
endinterface

// File: rtl/adc082s021_emu.sv
// adc082s021_emu: oversampled ADC082S021 SPI frame responder with one-frame channel pipelining
//   clk        - system clock, at least 8x sclk
//   n_reset    - asynchronous active-low reset
//   spi        - ss/sclk/mosi in, miso out (slave modport)
//   ch0_data   - sample returned when channel 0 is selected
//   ch1_data   - sample returned when channel 1 is selected
//   rx_ctrl    - control byte of the last complete frame
//   sample_ch  - channel of the current or most recent frame
//   busy       - frame in progress
//   frame_done - one-clk pulse on a complete frame
//   frame_err  - one-clk pulse on an aborted frame
module adc082s021_emu #(
    parameter int SYNC = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    adc082s021_emu_if.slave  spi,
    input  logic [7:0]       ch0_data,
    input  logic [7:0]       ch1_data,
    output logic [7:0]       rx_ctrl,
    output logic             sample_ch,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err
);
    typedef enum logic [1:0] {WAIT, IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [SYNC-1:0] ss_s, sclk_s, mosi_s;
    logic [SYNC:0] vld;
    logic ss_q, sclk_q, mosi_q, ss_p, sclk_p, mosi_p;
    logic ss_fe, ss_re, sck_re, sck_fe;
    logic [3:0] cnt;
    logic [7:0] ctrl;
    logic [15:0] tx;
    logic seen, next_ch;
    logic load, rx_sh, tx_sh, commit, abort, clr;

    assign ss_q = ss_s[SYNC-1];
    assign sclk_q = sclk_s[SYNC-1];
    assign mosi_q = mosi_s[SYNC-1];
    assign spi.miso = (state == SHIFT) & tx[15];

    // vld marks when the whole sync chain holds real pin samples, so a low ss
    // at reset release cannot masquerade as a falling edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ss_s <= '1;
            sclk_s <= '1;
            mosi_s <= '0;
            vld <= '0;
            ss_p <= 1'b1;
            sclk_p <= 1'b1;
            mosi_p <= 1'b0;
            ss_fe <= 1'b0;
            ss_re <= 1'b0;
            sck_re <= 1'b0;
            sck_fe <= 1'b0;
        end else begin
            ss_s <= {ss_s[SYNC-2:0], spi.ss};
            sclk_s <= {sclk_s[SYNC-2:0], spi.sclk};
            mosi_s <= {mosi_s[SYNC-2:0], spi.mosi};
            vld <= {vld[SYNC-1:0], 1'b1};
            ss_p <= ss_q;
            sclk_p <= sclk_q;
            mosi_p <= mosi_q;
            ss_fe <= ss_p & ~ss_q;
            ss_re <= ~ss_p & ss_q;
            sck_re <= ~sclk_p & sclk_q;
            sck_fe <= sclk_p & ~sclk_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= WAIT;
        else state <= state_n;
    end

    // ss edges take priority over sclk edges detected in the same clk.
    always_comb begin
        state_n = state;
        load = 1'b0;
        rx_sh = 1'b0;
        tx_sh = 1'b0;
        commit = 1'b0;
        abort = 1'b0;
        clr = 1'b0;
        case (state)
            WAIT: state_n = (ss_q && vld[SYNC]) ? IDLE : WAIT;
            IDLE: begin
                load = ss_fe;
                state_n = ss_fe ? SHIFT : IDLE;
            end
            SHIFT: begin
                abort = ss_re;
                rx_sh = !ss_re && sck_re;
                tx_sh = !ss_re && !sck_re && sck_fe && seen;
                commit = rx_sh && cnt == 4'd15;
                state_n = abort ? IDLE : commit ? DONE : SHIFT;
            end
            DONE: begin
                clr = ss_re;
                state_n = ss_re ? IDLE : DONE;
            end
            default: state_n = WAIT;
        endcase
    end

    // mosi_p lines up with the registered rising-edge detect.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tx <= '0;
            cnt <= '0;
            ctrl <= '0;
            seen <= 1'b0;
            rx_ctrl <= '0;
            next_ch <= 1'b0;
            sample_ch <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_done <= commit;
            frame_err <= abort;
            if (load) begin
                tx <= {4'h0, next_ch ? ch1_data : ch0_data, 4'h0};
                sample_ch <= next_ch;
                cnt <= '0;
                seen <= 1'b0;
                busy <= 1'b1;
            end
            if (rx_sh) begin
                cnt <= cnt + 4'd1;
                seen <= 1'b1;
                ctrl <= cnt[3] ? ctrl : {ctrl[6:0], mosi_p};
            end
            if (tx_sh) tx <= {tx[14:0], 1'b0};
            if (commit) begin
                rx_ctrl <= ctrl;
                next_ch <= ctrl[3];
            end
            if (abort || clr) busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adc082s021_emu.sv
// tb_adc082s021_emu: scoreboard bench for the ADC082S021 responder
module tb_adc082s021_emu;
    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic [7:0] ch0_data, ch1_data, rx_ctrl;
    logic sample_ch, busy, frame_done, frame_err;

    adc082s021_emu_if spi();

    adc082s021_emu #(.SYNC(2)) dut (
        .clk(clk),
        .n_reset(n_reset),
        .spi(spi),
        .ch0_data(ch0_data),
        .ch1_data(ch1_data),
        .rx_ctrl(rx_ctrl),
        .sample_ch(sample_ch),
        .busy(busy),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic [7:0] c;
        logic ch;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_ferr = 0;
    int rst_at = 0;
    int chg_at = 0;
    logic [7:0] chg_val = 8'h00;
    logic [15:0] got_word = 16'h0;
    logic nch;
    logic [7:0] rc;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w, input logic [7:0] c, input logic ch);
        exp_t x;
        x.w = w;
        x.c = c;
        x.ch = ch;
        q.push_back(x);
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_miso"}, 32'(spi.miso), 0);
        check({nm, "_rx_ctrl"}, 32'(rx_ctrl), 0);
        check({nm, "_sample_ch"}, 32'(sample_ch), 0);
        check({nm, "_busy"}, 32'(busy), 0);
        check({nm, "_frame_done"}, 32'(frame_done), 0);
        check({nm, "_frame_err"}, 32'(frame_err), 0);
    endtask

    // Master side: CPOL=1, mosi changes on falling sclk, miso sampled on rising sclk.
    task automatic frame(input logic [7:0] c, input int nr, input int hp, input bit chk_busy);
        logic [15:0] w = 16'h0;
        logic [7:0] sh = c;
        spi.ss = 1'b0;
        wait_clk(hp);
        for (int i = 0; i < nr; i++) begin
            spi.sclk = 1'b0;
            spi.mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            wait_clk(hp);
            if (rst_at == i + 1) begin
                n_reset = 1'b0;
                wait_clk(3);
                check_reset("midreset");
                n_reset = 1'b1;
            end
            if (chg_at == i + 1) ch0_data = chg_val;
            spi.sclk = 1'b1;
            if (i < 16) w = {w[14:0], spi.miso};
            else check("overrun_miso", 32'(spi.miso), 0);
            if (i == 15) got_word = w;
            wait_clk(hp);
        end
        if (chk_busy) check("busy_hold", 32'(busy), 1);
        spi.ss = 1'b1;
        wait_clk(5);
        if (chk_busy) check("busy_clr", 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        spi.ss = 1'b1;
        spi.sclk = 1'b1;
        spi.mosi = 1'b0;
        ch0_data = 8'hA5;
        ch1_data = 8'h3C;
        fork
            forever begin
                @(negedge clk);
                if (frame_done) begin
                    n_done++;
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_frame_done got=1 exp=0");
                    end else begin
                        e = q.pop_front();
                        check("miso_word", 32'(got_word), 32'(e.w));
                        check("rx_ctrl", 32'(rx_ctrl), 32'(e.c));
                        check("sample_ch", 32'(sample_ch), 32'(e.ch));
                    end
                end
                if (frame_err) n_ferr++;
            end
        join_none

        wait_clk(3);
        check_reset("por");
        n_reset = 1'b1;
        wait_clk(6);

        push(16'h0A50, 8'h08, 1'b0);
        frame(8'h08, 16, 16, 1'b0);
        push(16'h03C0, 8'h00, 1'b1);
        frame(8'h00, 16, 16, 1'b0);
        check("done_count_pipe", 32'(n_done), 2);

        frame(8'h08, 7, 16, 1'b0);
        wait_clk(2);
        check("abort_err", 32'(n_ferr), 1);
        check("abort_no_done", 32'(n_done), 2);
        check("abort_rx_ctrl", 32'(rx_ctrl), 32'h00);
        push(16'h0A50, 8'h08, 1'b0);
        frame(8'h08, 16, 16, 1'b0);

        push(16'h03C0, 8'h08, 1'b1);
        frame(8'h08, 20, 16, 1'b1);
        check("overrun_done_count", 32'(n_done), 4);

        rst_at = 9;
        frame(8'h00, 16, 16, 1'b0);
        rst_at = 0;
        check("reset_no_done", 32'(n_done), 4);
        check("reset_no_err", 32'(n_ferr), 1);
        push(16'h0A50, 8'h00, 1'b0);
        frame(8'h00, 16, 16, 1'b0);

        ch0_data = 8'h11;
        chg_val = 8'hEE;
        chg_at = 6;
        push(16'h0110, 8'h00, 1'b0);
        frame(8'h00, 16, 16, 1'b0);
        chg_at = 0;
        push(16'h0EE0, 8'h00, 1'b0);
        frame(8'h00, 16, 16, 1'b0);

        nch = 1'b0;
        for (int k = 0; k < 100; k++) begin
            rc = 8'($urandom);
            ch0_data = 8'($urandom);
            ch1_data = 8'($urandom);
            push({4'h0, nch ? ch1_data : ch0_data, 4'h0}, rc, nch);
            frame(rc, 16, 4, 1'b0);
            nch = rc[3];
        end

        wait_clk(5);
        check("total_done", 32'(n_done), 107);
        check("total_err", 32'(n_ferr), 1);
        check("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
